// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS32 pipeline: stall/flush,
// EX operand forwarding, mul/div sequencing and a saturating stall counter.
module pipeline_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_md_start,
  input  logic              id_md_op,
  input  logic              id_md_read,
  input  logic [4:0]        ex_rs,
  input  logic [4:0]        ex_rt,
  input  logic [4:0]        ex_rd,
  input  logic              ex_memrd,
  input  logic              ex_br_taken,
  input  logic [4:0]        mem_rd,
  input  logic              mem_gprwr,
  input  logic [4:0]        wb_rd,
  input  logic              wb_gprwr,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              md_go,
  output logic              md_op_o,
  output logic              md_busy,
  output logic              md_done,
  output logic [STAT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               md_op_q, md_op_d;
  logic [STAT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic lu, mh, stall, accept;

  // Select for one EX operand; EX/MEM wins over MEM/WB, r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic [4:0] m_rd, input logic m_wr,
                                         input logic [4:0] w_rd, input logic w_wr);
    if (m_wr && (m_rd != 5'd0) && (m_rd == r)) begin
      return 2'b10;
    end else if (w_wr && (w_rd != 5'd0) && (w_rd == r)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    lu = ex_memrd && (ex_rd != 5'd0) &&
         ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    mh = md_busy && (id_md_start || id_md_read);
    stall = (lu || mh) && !ex_br_taken;
    accept = id_md_start && !stall && !ex_br_taken && (state_q == StIdle) && !rst;
  end

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      fwd_a = fwd_sel(ex_rs, mem_rd, mem_gprwr, wb_rd, wb_gprwr);
      fwd_b = fwd_sel(ex_rt, mem_rd, mem_gprwr, wb_rd, wb_gprwr);
    end
  end

  // Mul/div sequencer: cnt counts down to zero; the zero cycle is the done cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_op_d = md_op_q;
    md_go   = 1'b0;
    md_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          md_go   = 1'b1;
          md_op_d = id_md_op;
          cnt_d   = id_md_op ? DivLoad : MulLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          md_done = !rst;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      md_op_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_op_q     <= md_op_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy   = (state_q == StBusy);
  assign md_op_o   = md_op_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for hazards/forwarding plus
// hand sequences for mul/div timing, reset mid-operation and counter saturation.
module tb_pipeline_ctrl;

  localparam int unsigned STAT_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, id_md_start, id_md_op, id_md_read;
  logic ex_memrd, ex_br_taken, mem_gprwr, wb_gprwr;
  logic pc_en, ifid_en, ifid_flush, idex_flush, md_go, md_op_o, md_busy, md_done;
  logic [1:0] fwd_a, fwd_b;
  logic [STAT_W-1:0] stall_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_start(id_md_start), .id_md_op(id_md_op), .id_md_read(id_md_read),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memrd(ex_memrd),
    .ex_br_taken(ex_br_taken), .mem_rd(mem_rd), .mem_gprwr(mem_gprwr),
    .wb_rd(wb_rd), .wb_gprwr(wb_gprwr),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .md_go(md_go), .md_op_o(md_op_o),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  typedef struct {
    string      nm;
    logic [4:0] id_rs, id_rt;
    logic       use_rs, use_rt;
    logic [4:0] ex_rd;
    logic       memrd, br;
    logic [4:0] ex_rs, ex_rt, mem_rd;
    logic       mem_wr;
    logic [4:0] wb_rd;
    logic       wb_wr;
    logic       pc_en, ifid_en, ifid_fl, idex_fl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_md_start = 0; id_md_op = 0; id_md_read = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_memrd = 0; ex_br_taken = 0;
    mem_rd = 0; mem_gprwr = 0; wb_rd = 0; wb_gprwr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             nm          idrs idrt urs urt exrd mrd br exrs exrt mrd mw wrd ww  pc ife iff ixf fa     fb
    vecs.push_back('{"idle",     0,   0,  0,  0,  0,  0,  0,  0,   0,  0,  0, 0,  0,  1, 1,  0,  0, 2'b00, 2'b00});
    vecs.push_back('{"lu_rs",    5,   0,  1,  0,  5,  1,  0,  0,   0,  0,  0, 0,  0,  0, 0,  0,  1, 2'b00, 2'b00});
    vecs.push_back('{"lu_rt",    0,   5,  0,  1,  5,  1,  0,  0,   0,  0,  0, 0,  0,  0, 0,  0,  1, 2'b00, 2'b00});
    vecs.push_back('{"lu_nouse", 5,   5,  0,  0,  5,  1,  0,  0,   0,  0,  0, 0,  0,  1, 1,  0,  0, 2'b00, 2'b00});
    vecs.push_back('{"lu_r0",    0,   0,  1,  1,  0,  1,  0,  0,   0,  0,  0, 0,  0,  1, 1,  0,  0, 2'b00, 2'b00});
    vecs.push_back('{"lu_br",    5,   0,  1,  0,  5,  1,  1,  0,   0,  0,  0, 0,  0,  1, 1,  1,  1, 2'b00, 2'b00});
    vecs.push_back('{"br_only",  0,   0,  0,  0,  0,  0,  1,  0,   0,  0,  0, 0,  0,  1, 1,  1,  1, 2'b00, 2'b00});
    vecs.push_back('{"fwd_mem",  0,   0,  0,  0,  0,  0,  0,  0,   7,  7,  1, 7,  1,  1, 1,  0,  0, 2'b00, 2'b10});
    vecs.push_back('{"fwd_r0",   0,   0,  0,  0,  0,  0,  0,  0,   0,  0,  1, 0,  1,  1, 1,  0,  0, 2'b00, 2'b00});
    vecs.push_back('{"fwd_wb",   0,   0,  0,  0,  0,  0,  0,  7,   7,  7,  0, 7,  1,  1, 1,  0,  0, 2'b01, 2'b01});
    vecs.push_back('{"fwd_mix",  0,   0,  0,  0,  0,  0,  0,  4,   3,  3,  1, 4,  1,  1, 1,  0,  0, 2'b01, 2'b10});
    vecs.push_back('{"fwd_nowr", 0,   0,  0,  0,  0,  0,  0,  8,   9,  9,  0, 9,  0,  1, 1,  0,  0, 2'b00, 2'b00});
    vecs.push_back('{"lu_miss",  6,   5,  1,  0,  5,  1,  0,  0,   0,  0,  0, 0,  0,  1, 1,  0,  0, 2'b00, 2'b00});
    vecs.push_back('{"lu_fwd",   5,   0,  1,  0,  5,  1,  0,  2,   0,  2,  1, 0,  0,  0, 0,  0,  1, 2'b10, 2'b00});

    // Reset: outputs forced even with hazards and forwardable registers present.
    clr_in();
    rst = 1'b1;
    repeat (2) step();
    mem_gprwr = 1; mem_rd = 3; ex_rs = 3; ex_rt = 3;
    ex_memrd = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1; id_md_start = 1;
    #1;
    chk("rst_pc_en", pc_en, 0);
    chk("rst_ifid_en", ifid_en, 0);
    chk("rst_ifid_flush", ifid_flush, 1);
    chk("rst_idex_flush", idex_flush, 1);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_md_go", md_go, 0);
    chk("rst_md_done", md_done, 0);
    step();
    rst = 1'b0;
    clr_in();
    #1;
    chk("post_rst_cnt", stall_cnt, 0);
    chk("post_rst_busy", md_busy, 0);
    chk("post_rst_op", md_op_o, 0);
    chk("post_rst_pc_en", pc_en, 1);

    // Load r5 in EX, ID reads r5: one stall, then the load forwards from EX/MEM.
    ex_memrd = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    #1;
    chk("lu_pc_en", pc_en, 0);
    chk("lu_ifid_en", ifid_en, 0);
    chk("lu_idex_flush", idex_flush, 1);
    chk("lu_ifid_flush", ifid_flush, 0);
    exp_cnt++;
    step();
    chk("lu_cnt1", stall_cnt, exp_cnt);
    ex_memrd = 0; ex_rd = 0; mem_rd = 5; mem_gprwr = 1; ex_rs = 5;
    #1;
    chk("lu_fwd_a", fwd_a, 2'b10);
    chk("lu_release", pc_en, 1);
    step();
    chk("lu_cnt_hold", stall_cnt, exp_cnt);

    foreach (vecs[i]) begin
      clr_in();
      id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt;
      id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
      ex_rd = vecs[i].ex_rd; ex_memrd = vecs[i].memrd; ex_br_taken = vecs[i].br;
      ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt;
      mem_rd = vecs[i].mem_rd; mem_gprwr = vecs[i].mem_wr;
      wb_rd = vecs[i].wb_rd; wb_gprwr = vecs[i].wb_wr;
      #1;
      chk({vecs[i].nm, ".pc_en"}, pc_en, vecs[i].pc_en);
      chk({vecs[i].nm, ".ifid_en"}, ifid_en, vecs[i].ifid_en);
      chk({vecs[i].nm, ".ifid_flush"}, ifid_flush, vecs[i].ifid_fl);
      chk({vecs[i].nm, ".idex_flush"}, idex_flush, vecs[i].idex_fl);
      chk({vecs[i].nm, ".fwd_a"}, fwd_a, vecs[i].fa);
      chk({vecs[i].nm, ".fwd_b"}, fwd_b, vecs[i].fb);
      if (!vecs[i].pc_en) exp_cnt++;
      step();
      chk({vecs[i].nm, ".stall_cnt"}, stall_cnt, exp_cnt);
    end
    clr_in();

    // mult accepted at t; a div waits in ID from t+2 and is accepted at t+5.
    id_md_start = 1; id_md_op = 0;
    #1;
    chk("mul_go", md_go, 1);
    chk("mul_pc_en", pc_en, 1);
    step();
    id_md_start = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k >= 2) begin
        id_md_start = 1; id_md_op = 1;
      end
      #1;
      chk("mul_busy", md_busy, 1);
      chk("mul_done", md_done, (k == 4));
      chk("mul_go_quiet", md_go, 0);
      if (k == 1) chk("mul_op", md_op_o, 0);
      if (k >= 2) begin
        chk("mul_wait_stall", pc_en, 0);
        exp_cnt++;
      end
      step();
    end
    #1;
    chk("mul_idle", md_busy, 0);
    chk("mul_no_done", md_done, 0);
    chk("div_go", md_go, 1);
    chk("div_go_pc_en", pc_en, 1);
    step();

    // div busy with mflo in ID: stalled until md_done; a taken branch mid-way
    // flushes without aborting the divide.
    id_md_start = 0; id_md_read = 1;
    for (int k = 1; k <= 32; k++) begin
      ex_br_taken = (k == 5);
      #1;
      chk("div_busy", md_busy, 1);
      chk("div_done", md_done, (k == 32));
      chk("div_pc_en", pc_en, (k == 5));
      if (k == 5) chk("div_br_flush", ifid_flush, 1);
      if (k == 1) chk("div_op", md_op_o, 1);
      if (k != 5) exp_cnt++;
      step();
    end
    ex_br_taken = 0;
    #1;
    chk("mflo_busy", md_busy, 0);
    chk("mflo_issue", pc_en, 1);
    chk("mflo_no_done", md_done, 0);
    chk("mflo_cnt", stall_cnt, exp_cnt);
    step();

    // Reset in busy cycle 10 of a div abandons it with no md_done.
    clr_in();
    id_md_start = 1; id_md_op = 1;
    #1;
    chk("div2_go", md_go, 1);
    step();
    id_md_start = 0;
    repeat (9) step();
    rst = 1'b1;
    #1;
    chk("div2_rst_busy_still", md_busy, 1);
    chk("div2_rst_no_done", md_done, 0);
    step();
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    chk("div2_abort_busy", md_busy, 0);
    chk("div2_abort_cnt", stall_cnt, 0);
    for (int k = 0; k < 40; k++) begin
      chk("div2_abort_done", {md_busy, md_done}, 0);
      step();
    end

    // Saturation: continuous load-use stall.
    ex_memrd = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    repeat ((1 << STAT_W) - 2) step();
    chk("sat_pre", stall_cnt, (1 << STAT_W) - 2);
    step();
    chk("sat_max", stall_cnt, (1 << STAT_W) - 1);
    repeat (3) step();
    chk("sat_hold", stall_cnt, (1 << STAT_W) - 1);
    clr_in();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
